// File: rtl/mem_access_ctrl.sv
// SRAM/MMIO access controller behind the SLC-3 sequencer: turns level read/write requests into
// timed async-SRAM cycles with WAIT_CYCLES strobe width. Define MEM_ACCESS_MMIO_EN to decode IO_ADDR.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_RD,
  input  logic        Req_WR,
  input  logic [15:0] Addr,
  input  logic [15:0] Wdata,
  output logic [15:0] Rdata,
  output logic        Ack,
  output logic        Busy,
  output logic [19:0] SRAM_ADDR,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  input  logic [15:0] Switches,
  output logic [15:0] Hex_out
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, IO, ACK
  } state_t;

  state_t          state_q, state_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            accept_c;
  logic            io_hit_c;

  assign accept_c = (state_q == IDLE) && (Req_RD || Req_WR);

`ifdef MEM_ACCESS_MMIO_EN
  logic        rd_q;
  logic [15:0] sw_meta, sw_sync;
  assign io_hit_c = (Addr == IO_ADDR);
`else
  logic        unused_switches;
  logic [15:0] unused_io_addr;
  assign io_hit_c        = 1'b0;
  assign unused_switches = ^Switches;
  assign unused_io_addr  = IO_ADDR;
  assign Hex_out         = '0;
`endif

  // Next state and wait counter
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (io_hit_c) begin
            state_nxt = IO;
          end else if (Req_RD) begin
            state_nxt = RD;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = WR_SETUP;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) state_nxt = ACK;
        else             cnt_nxt   = cnt_q - CW'(1);
      end
      WR_SETUP: begin
        state_nxt = WR_PULSE;
        cnt_nxt   = CNT_LOAD;
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_nxt = WR_HOLD;
        else             cnt_nxt   = cnt_q - CW'(1);
      end
      WR_HOLD: state_nxt = ACK;
`ifdef MEM_ACCESS_MMIO_EN
      IO:      state_nxt = ACK;
`endif
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, data path and strobes; strobes are decoded from the next state so they are registered
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      Rdata       <= '0;
      Ack         <= 1'b0;
      Busy        <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
`ifdef MEM_ACCESS_MMIO_EN
      rd_q        <= 1'b0;
      sw_meta     <= '0;
      sw_sync     <= '0;
      Hex_out     <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;

      // SRAM_ADDR and SRAM_DQ_out double as the latched address and write data
      if (accept_c) begin
        SRAM_ADDR <= {4'h0, Addr};
        if (!Req_RD) SRAM_DQ_out <= Wdata;
      end

      if (state_q == RD && cnt_q == '0) Rdata <= SRAM_DQ_in;

`ifdef MEM_ACCESS_MMIO_EN
      sw_meta <= Switches;
      sw_sync <= sw_meta;
      if (accept_c) rd_q <= Req_RD;
      if (state_q == IO) begin
        if (rd_q) Rdata   <= sw_sync;
        else      Hex_out <= SRAM_DQ_out;
      end
`endif

      Ack        <= (state_nxt == ACK);
      Busy       <= (state_nxt != IDLE);
      SRAM_CE_N  <= !(state_nxt inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
      SRAM_UB_N  <= !(state_nxt inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
      SRAM_LB_N  <= !(state_nxt inside {RD, WR_SETUP, WR_PULSE, WR_HOLD});
      SRAM_OE_N  <= (state_nxt != RD);
      SRAM_WE_N  <= (state_nxt != WR_PULSE);
      SRAM_DQ_oe <= (state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD});
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a WAIT_CYCLES=2 instance with an SRAM model, plus
// WAIT_CYCLES=1 and 15 instances for strobe-width extremes.
module tb_mem_access_ctrl;

  localparam int unsigned W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [15:0] addr = '0, wdata = '0, switches = '0;
  logic [15:0] rdata, dq_in, dq_out, hex_out;
  logic [19:0] sram_addr;
  logic        ack, busy, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

  mem_access_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF)) dut (
    .Clk(clk), .Reset(rst_n), .Req_RD(req_rd), .Req_WR(req_wr), .Addr(addr), .Wdata(wdata),
    .Rdata(rdata), .Ack(ack), .Busy(busy), .SRAM_ADDR(sram_addr), .SRAM_DQ_in(dq_in),
    .SRAM_DQ_out(dq_out), .SRAM_DQ_oe(dq_oe), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .Switches(switches), .Hex_out(hex_out)
  );

  // Strobe-width extremes share one read address and a constant SRAM bus
  logic        req_a1 = 1'b0, req_a15 = 1'b0;
  logic [15:0] aux_addr = 16'h0010;
  logic [15:0] a1_rdata, a1_dq_out, a1_hex, a15_rdata, a15_dq_out, a15_hex;
  logic [19:0] a1_sram_addr, a15_sram_addr;
  logic        a1_ack, a1_busy, a1_dq_oe, a1_ce_n, a1_oe_n, a1_we_n, a1_ub_n, a1_lb_n;
  logic        a15_ack, a15_busy, a15_dq_oe, a15_ce_n, a15_oe_n, a15_we_n, a15_ub_n, a15_lb_n;

  mem_access_ctrl #(.WAIT_CYCLES(1)) dut_w1 (
    .Clk(clk), .Reset(rst_n), .Req_RD(req_a1), .Req_WR(1'b0), .Addr(aux_addr), .Wdata(16'h0),
    .Rdata(a1_rdata), .Ack(a1_ack), .Busy(a1_busy), .SRAM_ADDR(a1_sram_addr),
    .SRAM_DQ_in(16'h4321), .SRAM_DQ_out(a1_dq_out), .SRAM_DQ_oe(a1_dq_oe), .SRAM_CE_N(a1_ce_n),
    .SRAM_OE_N(a1_oe_n), .SRAM_WE_N(a1_we_n), .SRAM_UB_N(a1_ub_n), .SRAM_LB_N(a1_lb_n),
    .Switches(16'h0), .Hex_out(a1_hex)
  );

  mem_access_ctrl #(.WAIT_CYCLES(15)) dut_w15 (
    .Clk(clk), .Reset(rst_n), .Req_RD(req_a15), .Req_WR(1'b0), .Addr(aux_addr), .Wdata(16'h0),
    .Rdata(a15_rdata), .Ack(a15_ack), .Busy(a15_busy), .SRAM_ADDR(a15_sram_addr),
    .SRAM_DQ_in(16'h4321), .SRAM_DQ_out(a15_dq_out), .SRAM_DQ_oe(a15_dq_oe), .SRAM_CE_N(a15_ce_n),
    .SRAM_OE_N(a15_oe_n), .SRAM_WE_N(a15_we_n), .SRAM_UB_N(a15_ub_n), .SRAM_LB_N(a15_lb_n),
    .Switches(16'h0), .Hex_out(a15_hex)
  );

  // Async SRAM model: reads while CE_N/OE_N low, writes on clock edges inside the WE_N pulse
  logic [15:0] mem [0:65535];
  assign dq_in = (!ce_n && !oe_n) ? mem[sram_addr[15:0]] : 16'hDEAD;
  always @(posedge clk) if (!ce_n && !we_n && dq_oe) mem[sram_addr[15:0]] <= dq_out;

  int contention = 0, lane_err = 0;
  always @(negedge clk) begin
    if (dq_oe && !oe_n) contention++;
    if (ub_n !== ce_n || lb_n !== ce_n) lane_err++;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access; Addr/Wdata are scrambled after accept to prove they were latched
  task automatic access(input logic rd, input logic [15:0] a, input logic [15:0] wd,
                        output int lat, output int oe_lo, output int we_lo,
                        output int dqoe_hi, output int ce_lo, output logic addr_ok);
    lat = 0; oe_lo = 0; we_lo = 0; dqoe_hi = 0; ce_lo = 0; addr_ok = 1'b1;
    @(negedge clk);
    req_rd = rd; req_wr = !rd; addr = a; wdata = wd;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin addr = ~a; wdata = ~wd; end
      if (!ce_n && sram_addr !== {4'h0, a}) addr_ok = 1'b0;
      if (!oe_n) oe_lo++;
      if (!we_n) we_lo++;
      if (dq_oe) dqoe_hi++;
      if (!ce_n) ce_lo++;
      if (ack) break;
    end
    if (!ack) lat = 99;
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  int lat, oe_lo, we_lo, dqoe_hi, ce_lo, lat2, acks;
  logic addr_ok;
  int c, lat_a1, lat_a15, oe_a1, oe_a15;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0031] = 16'h1234;
    mem[16'hFFFE] = 16'h7777;
    mem[16'hFFFF] = 16'h5A5A;
    mem[16'h0050] = 16'h1111;
    switches = 16'h00A5;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_ctl", {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, ack, busy}, 32'hF8);
    chk("rst_data", {rdata, dq_out}, 32'h0);
    chk("rst_addr_hex", {sram_addr[15:0], hex_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    access(1'b1, 16'h0031, 16'h0, lat, oe_lo, we_lo, dqoe_hi, ce_lo, addr_ok);
    chk("rd_lat", lat, W + 1);
    chk("rd_oe_width", oe_lo, W);
    chk("rd_ce_dqoe", {ce_lo[15:0], dqoe_hi[15:0]}, {16'(W), 16'h0});
    chk("rd_data", rdata, 16'h1234);
    chk("rd_addr_held", addr_ok, 1);

    access(1'b0, 16'h0040, 16'hBEEF, lat, oe_lo, we_lo, dqoe_hi, ce_lo, addr_ok);
    chk("wr_lat", lat, W + 3);
    chk("wr_we_width", we_lo, W);
    chk("wr_dqoe", dqoe_hi, W + 2);
    chk("wr_oe_ce", {oe_lo[15:0], ce_lo[15:0]}, {16'h0, 16'(W + 2)});
    chk("wr_mem", mem[16'h0040], 16'hBEEF);
    chk("wr_addr_held", addr_ok, 1);

    access(1'b1, 16'h0040, 16'h0, lat, oe_lo, we_lo, dqoe_hi, ce_lo, addr_ok);
    chk("rdback", rdata, 16'hBEEF);

    access(1'b1, 16'hFFFF, 16'h0, lat, oe_lo, we_lo, dqoe_hi, ce_lo, addr_ok);
`ifdef MEM_ACCESS_MMIO_EN
    chk("io_rd_lat", lat, 2);
    chk("io_rd_ce", ce_lo, 0);
    chk("io_rd_data", rdata, 16'h00A5);
`else
    chk("io_rd_lat", lat, W + 1);
    chk("io_rd_ce", ce_lo, W);
    chk("io_rd_data", rdata, 16'h5A5A);
`endif

    access(1'b0, 16'hFFFF, 16'h0C0D, lat, oe_lo, we_lo, dqoe_hi, ce_lo, addr_ok);
`ifdef MEM_ACCESS_MMIO_EN
    chk("io_wr_lat", lat, 2);
    chk("io_wr_hex", hex_out, 16'h0C0D);
    chk("io_wr_mem", mem[16'hFFFF], 16'h5A5A);
`else
    chk("io_wr_lat", lat, W + 3);
    chk("io_wr_hex", hex_out, 16'h0000);
    chk("io_wr_mem", mem[16'hFFFF], 16'h0C0D);
`endif

    access(1'b1, 16'hFFFE, 16'h0, lat, oe_lo, we_lo, dqoe_hi, ce_lo, addr_ok);
    chk("fffe_lat", lat, W + 1);
    chk("fffe_data", rdata, 16'h7777);

    // Simultaneous read and write: read first, write accepted right after Ack
    @(negedge clk);
    req_rd = 1'b1; req_wr = 1'b1; addr = 16'h0050; wdata = 16'hCAFE;
    lat = 0;
    for (int i = 0; i < 40 && !ack; i++) begin @(negedge clk); lat++; end
    chk("both_rd_lat", lat, W + 1);
    chk("both_rd_data", rdata, 16'h1111);
    req_rd = 1'b0;
    lat2 = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); lat2++; if (ack) break; end
    req_wr = 1'b0;
    chk("both_wr_lat", lat2, W + 4);
    chk("both_wr_mem", mem[16'h0050], 16'hCAFE);

    // Reset in the middle of the write pulse
    @(negedge clk);
    req_wr = 1'b1; addr = 16'h0060; wdata = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_pulse", {we_n, ce_n}, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async", {ce_n, we_n, oe_n, dq_oe, busy, ack}, 6'b111000);
    req_wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (4) begin @(negedge clk); if (ack) acks++; end
    chk("abort_no_ack", acks, 0);
    chk("abort_idle", busy, 0);
    chk("abort_mem", mem[16'h0060], 16'h0000);

    access(1'b1, 16'h0031, 16'h0, lat, oe_lo, we_lo, dqoe_hi, ce_lo, addr_ok);
    chk("post_abort_rd", {lat[15:0], rdata}, {16'(W + 1), 16'h1234});

    // WAIT_CYCLES = 1 and 15 side by side
    @(negedge clk);
    req_a1 = 1'b1; req_a15 = 1'b1;
    c = 0; lat_a1 = 0; lat_a15 = 0; oe_a1 = 0; oe_a15 = 0;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      c++;
      if (!a1_oe_n) oe_a1++;
      if (!a15_oe_n) oe_a15++;
      if (a1_ack && lat_a1 == 0) begin lat_a1 = c; req_a1 = 1'b0; end
      if (a15_ack && lat_a15 == 0) begin lat_a15 = c; req_a15 = 1'b0; end
      if (lat_a1 != 0 && lat_a15 != 0) break;
    end
    req_a1 = 1'b0; req_a15 = 1'b0;
    repeat (3) @(negedge clk);
    chk("w1_oe_width", oe_a1, 1);
    chk("w1_lat", lat_a1, 2);
    chk("w15_oe_width", oe_a15, 15);
    chk("w15_lat", lat_a15, 16);
    chk("wx_data", {a1_rdata, a15_rdata}, 32'h43214321);

    chk("no_contention", contention, 0);
    chk("byte_lanes", lane_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
